// File: rtl/scratch_prog_loader_if.sv
// Bus bundle between the HPS download stream / SDRAM programming port and the loader.
interface scratch_prog_loader_if;
  localparam int unsigned IOCTL_AW = 25;
  localparam int unsigned PROG_AW  = 22;
  localparam int unsigned DW       = 8;
  localparam int unsigned MW       = 2;

  logic                downloading;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [DW-1:0]       ioctl_data;
  logic                ioctl_wr;
  logic                sdram_ack;
  logic [PROG_AW-1:0]  prog_addr;
  logic [DW-1:0]       prog_data;
  logic [MW-1:0]       prog_mask;
  logic                prog_we;
  logic                prog_rd;
  logic                dwnld_busy;
  logic                overflow;

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask, prog_we, prog_rd, dwnld_busy, overflow
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask, prog_we, prog_rd, dwnld_busy, overflow
  );
endinterface

// File: rtl/scratch_prog_loader.sv
// Turns the HPS byte download stream into held SDRAM byte writes, relocating the
// graphics region and absorbing one byte of back-pressure in a single-entry buffer.
module scratch_prog_loader #(
  parameter logic [24:0] GFX_START  = 25'h0_8000,
  parameter logic [21:0] GFX_OFFSET = 22'h10_0000,
  parameter logic [24:0] ROM_END    = 25'h1_0000
) (
  input logic                  clk,
  input logic                  rst,
  scratch_prog_loader_if.slave bus
);
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    r_state,    w_state_nxt;
  logic [AW-1:0] r_addr,     w_addr_nxt;
  logic [DW-1:0] r_data,     w_data_nxt;
  logic [MW-1:0] r_mask,     w_mask_nxt;
  logic          r_we,       w_we_nxt;
  logic          r_buf_full, w_buf_full_nxt;
  logic [AW-1:0] r_buf_addr, w_buf_addr_nxt;
  logic [DW-1:0] r_buf_data, w_buf_data_nxt;
  logic [MW-1:0] r_buf_mask, w_buf_mask_nxt;
  logic          r_ovf,      w_ovf_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_dl_q;

  logic          w_accept;
  logic [AW-1:0] w_map_addr;
  logic [MW-1:0] w_map_mask;

  // Byte qualification and address/mask mapping of the incoming byte
  assign w_accept   = bus.ioctl_wr && bus.downloading && (bus.ioctl_addr < ROM_END);
  assign w_map_addr = bus.ioctl_addr[22:1] +
                      ((bus.ioctl_addr >= GFX_START) ? GFX_OFFSET : AW'(0));
  assign w_map_mask = bus.ioctl_addr[0] ? 2'b01 : 2'b10;

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_mask_nxt     = r_mask;
    w_we_nxt       = r_we;
    w_buf_full_nxt = r_buf_full;
    w_buf_addr_nxt = r_buf_addr;
    w_buf_data_nxt = r_buf_data;
    w_buf_mask_nxt = r_buf_mask;
    w_ovf_nxt      = r_ovf;
    w_busy_nxt     = bus.downloading || (r_state != S_IDLE) || r_buf_full;

    // A fresh download clears the sticky flag; a drop in the same cycle still sets it
    if (bus.downloading && !r_dl_q) begin
      w_ovf_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nxt  = w_map_addr;
          w_data_nxt  = bus.ioctl_data;
          w_mask_nxt  = w_map_mask;
          w_we_nxt    = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          if (!r_buf_full) begin
            w_buf_full_nxt = 1'b1;
            w_buf_addr_nxt = w_map_addr;
            w_buf_data_nxt = bus.ioctl_data;
            w_buf_mask_nxt = w_map_mask;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
        if (bus.sdram_ack) begin
          w_we_nxt    = 1'b0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // A byte arriving here with the buffer empty passes straight to the port
        if (r_buf_full) begin
          w_addr_nxt     = r_buf_addr;
          w_data_nxt     = r_buf_data;
          w_mask_nxt     = r_buf_mask;
          w_we_nxt       = 1'b1;
          w_buf_full_nxt = 1'b0;
          w_state_nxt    = S_WRITE;
          if (w_accept) begin
            w_ovf_nxt = 1'b1;
          end
        end else if (w_accept) begin
          w_addr_nxt  = w_map_addr;
          w_data_nxt  = bus.ioctl_data;
          w_mask_nxt  = w_map_mask;
          w_we_nxt    = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_we_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= 2'b11;
      r_we       <= 1'b0;
      r_buf_full <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_buf_mask <= 2'b11;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_dl_q     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_mask     <= w_mask_nxt;
      r_we       <= w_we_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_buf_addr <= w_buf_addr_nxt;
      r_buf_data <= w_buf_data_nxt;
      r_buf_mask <= w_buf_mask_nxt;
      r_ovf      <= w_ovf_nxt;
      r_busy     <= w_busy_nxt;
      r_dl_q     <= bus.downloading;
    end
  end

  assign bus.prog_addr  = r_addr;
  assign bus.prog_data  = r_data;
  assign bus.prog_mask  = r_mask;
  assign bus.prog_we    = r_we;
  assign bus.prog_rd    = 1'b0;
  assign bus.dwnld_busy = r_busy;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_scratch_prog_loader.sv
// Bench for scratch_prog_loader: directed vectors plus randomized traffic against a
// queue-based reference model of the download path.
module tb_scratch_prog_loader;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;

  scratch_prog_loader_if bif ();

  scratch_prog_loader dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] a;
    logic [7:0]  d;
    logic [1:0]  m;
  } wr_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [21:0] exp_addr;
    logic [1:0]  exp_mask;
  } vec_t;

  // Reference model: outstanding writes as a queue, front is the one on the port
  wr_t q[$];
  bit  m_gap = 1'b0;
  wr_t m_cur = '{a: 22'd0, d: 8'd0, m: 2'b11};
  bit  m_ovf = 1'b0;
  bit  m_busy = 1'b0;
  bit  m_dlq = 1'b0;

  function automatic wr_t map_byte(logic [24:0] addr, logic [7:0] data);
    wr_t w;
    logic [24:0] word;
    word = addr >> 1;
    if (addr >= 25'h0_8000) word = word + 25'h10_0000;
    w.a = word[21:0];
    w.d = data;
    w.m = (addr % 2 == 1) ? 2'b01 : 2'b10;
    return w;
  endfunction

  task automatic model_step();
    bit writing, acc, nbusy;
    int cap;
    if (rst) begin
      q.delete();
      m_gap  = 1'b0;
      m_cur  = '{a: 22'd0, d: 8'd0, m: 2'b11};
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_dlq  = 1'b0;
      return;
    end
    writing = (q.size() > 0) && !m_gap;
    acc     = bif.ioctl_wr && bif.downloading && (bif.ioctl_addr < 25'h1_0000);
    nbusy   = bif.downloading || (q.size() > 0) || m_gap;
    if (bif.downloading && !m_dlq) m_ovf = 1'b0;
    if (acc) begin
      cap = writing ? 2 : 1;
      if (q.size() < cap) q.push_back(map_byte(bif.ioctl_addr, bif.ioctl_data));
      else m_ovf = 1'b1;
    end
    if (writing && bif.sdram_ack) begin
      void'(q.pop_front());
      m_gap = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end
    m_busy = nbusy;
    m_dlq  = bif.downloading;
    if ((q.size() > 0) && !m_gap) m_cur = q[0];
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_we",   32'(bif.prog_we),    32'((q.size() > 0) && !m_gap));
      chk("mon_addr", 32'(bif.prog_addr),  32'(m_cur.a));
      chk("mon_data", 32'(bif.prog_data),  32'(m_cur.d));
      chk("mon_mask", 32'(bif.prog_mask),  32'(m_cur.m));
      chk("mon_busy", 32'(bif.dwnld_busy), 32'(m_busy));
      chk("mon_ovf",  32'(bif.overflow),   32'(m_ovf));
      chk("mon_rd",   32'(bif.prog_rd),    32'd0);
    end
  end

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_we(int budget);
    int k;
    k = 0;
    while (!bif.prog_we && k < budget) begin
      tick();
      k++;
    end
    chk("we_timeout", 32'(bif.prog_we), 32'd1);
  endtask

  task automatic send(logic [24:0] addr, logic [7:0] data);
    bif.ioctl_addr = addr;
    bif.ioctl_data = data;
    bif.ioctl_wr   = 1'b1;
    tick();
    bif.ioctl_wr   = 1'b0;
  endtask

  task automatic ack_pulse();
    bif.sdram_ack = 1'b1;
    tick();
    bif.sdram_ack = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{addr: 25'h000_0003, data: 8'hA5, exp_addr: 22'h00_0001, exp_mask: 2'b01};
    vecs[1] = '{addr: 25'h000_8000, data: 8'h3C, exp_addr: 22'h10_4000, exp_mask: 2'b10};
    vecs[2] = '{addr: 25'h000_7FFF, data: 8'hC3, exp_addr: 22'h00_3FFF, exp_mask: 2'b01};
    vecs[3] = '{addr: 25'h000_0000, data: 8'h01, exp_addr: 22'h00_0000, exp_mask: 2'b10};
    vecs[4] = '{addr: 25'h000_FFFF, data: 8'hFE, exp_addr: 22'h10_7FFF, exp_mask: 2'b01};
    vecs[5] = '{addr: 25'h000_8001, data: 8'h77, exp_addr: 22'h10_4000, exp_mask: 2'b01};

    rst = 1'b1;
    bif.downloading = 1'b0;
    bif.ioctl_addr  = '0;
    bif.ioctl_data  = '0;
    bif.ioctl_wr    = 1'b0;
    bif.sdram_ack   = 1'b0;
    tick(3);
    chk("rst_we",   32'(bif.prog_we),    32'd0);
    chk("rst_addr", 32'(bif.prog_addr),  32'd0);
    chk("rst_data", 32'(bif.prog_data),  32'd0);
    chk("rst_mask", 32'(bif.prog_mask),  32'd3);
    chk("rst_busy", 32'(bif.dwnld_busy), 32'd0);
    chk("rst_ovf",  32'(bif.overflow),   32'd0);
    chk("rst_rd",   32'(bif.prog_rd),    32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Mapping table: one held write per vector, ack after three write cycles
    bif.downloading = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].addr, vecs[i].data);
      wait_we(4);
      chk("vec_addr", 32'(bif.prog_addr), 32'(vecs[i].exp_addr));
      chk("vec_mask", 32'(bif.prog_mask), 32'(vecs[i].exp_mask));
      chk("vec_data", 32'(bif.prog_data), 32'(vecs[i].data));
      tick(2);
      chk("vec_hold", 32'(bif.prog_we), 32'd1);
      ack_pulse();
      chk("vec_drop", 32'(bif.prog_we), 32'd0);
      tick(2);
    end
    bif.downloading = 1'b0;
    tick();
    chk("busy_fall", 32'(bif.dwnld_busy), 32'd0);

    // Ignored bytes: out of range, and outside a download
    bif.downloading = 1'b1;
    tick();
    send(25'h001_0000, 8'h55);
    tick(2);
    chk("range_we",  32'(bif.prog_we),  32'd0);
    chk("range_ovf", 32'(bif.overflow), 32'd0);
    bif.downloading = 1'b0;
    send(25'h000_0010, 8'h66);
    tick();
    chk("nodl_we", 32'(bif.prog_we), 32'd0);

    // Back-pressure: three bytes, ack held off for ten cycles
    bif.downloading = 1'b1;
    tick();
    bif.ioctl_wr = 1'b1;
    bif.ioctl_addr = 25'h20; bif.ioctl_data = 8'h11; tick();
    bif.ioctl_addr = 25'h21; bif.ioctl_data = 8'h22; tick();
    bif.ioctl_addr = 25'h22; bif.ioctl_data = 8'h33; tick();
    bif.ioctl_wr = 1'b0;
    chk("bp_addr1", 32'(bif.prog_addr), 32'h10);
    chk("bp_data1", 32'(bif.prog_data), 32'h11);
    chk("bp_ovf",   32'(bif.overflow),  32'd1);
    tick(7);
    ack_pulse();
    chk("bp_gap", 32'(bif.prog_we), 32'd0);
    tick();
    chk("bp_we2",   32'(bif.prog_we),   32'd1);
    chk("bp_data2", 32'(bif.prog_data), 32'h22);
    chk("bp_mask2", 32'(bif.prog_mask), 32'h1);
    ack_pulse();
    tick(2);
    chk("bp_idle", 32'(bif.prog_we), 32'd0);
    bif.downloading = 1'b0;
    tick(2);
    chk("bp_sticky", 32'(bif.overflow), 32'd1);
    bif.downloading = 1'b1;
    tick();
    chk("bp_clear", 32'(bif.overflow), 32'd0);

    // Ack and a new byte in the same cycle with the buffer empty
    send(25'h40, 8'h4A);
    tick();
    bif.sdram_ack  = 1'b1;
    bif.ioctl_addr = 25'h41;
    bif.ioctl_data = 8'h5B;
    bif.ioctl_wr   = 1'b1;
    tick();
    bif.sdram_ack = 1'b0;
    bif.ioctl_wr  = 1'b0;
    chk("sim_gap", 32'(bif.prog_we),  32'd0);
    chk("sim_ovf", 32'(bif.overflow), 32'd0);
    tick();
    chk("sim_we",   32'(bif.prog_we),   32'd1);
    chk("sim_data", 32'(bif.prog_data), 32'h5B);
    ack_pulse();
    tick(2);

    // Reset while writing with the buffer full
    send(25'h50, 8'hC1);
    send(25'h51, 8'hC2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.downloading = 1'b0;
    chk("mr_we",   32'(bif.prog_we),    32'd0);
    chk("mr_busy", 32'(bif.dwnld_busy), 32'd0);
    chk("mr_addr", 32'(bif.prog_addr),  32'd0);
    chk("mr_mask", 32'(bif.prog_mask),  32'd3);
    chk("mr_data", 32'(bif.prog_data),  32'd0);
    ack_pulse();
    tick(3);
    chk("mr_nowr", 32'(bif.prog_we), 32'd0);

    // Randomized traffic checked cycle by cycle by the monitor
    bif.downloading = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 63) == 0) bif.downloading = ~bif.downloading;
      bif.ioctl_wr = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: bif.ioctl_addr = 25'($urandom_range(0, 16'hFFFF));
        1: bif.ioctl_addr = 25'($urandom_range(16'h7FF0, 16'h800F));
        2: bif.ioctl_addr = 25'($urandom_range(17'h0FFF0, 17'h1000F));
        default: bif.ioctl_addr = 25'($urandom);
      endcase
      bif.ioctl_data = 8'($urandom);
      bif.sdram_ack  = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0;
    bif.ioctl_wr    = 1'b0;
    bif.downloading = 1'b0;
    bif.sdram_ack   = 1'b1;
    tick(8);
    bif.sdram_ack = 1'b0;
    tick(2);
    chk("end_busy", 32'(bif.dwnld_busy), 32'd0);
    chk("end_we",   32'(bif.prog_we),    32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
